// File: rtl/accel_pkg.sv
// Shared op codes, ADXL345 register map and sequencer state encoding.
package accel_pkg;

    typedef enum logic [2:0] {
        OP_START   = 3'd0,
        OP_STOP    = 3'd1,
        OP_WRITE   = 3'd2,
        OP_RD_ACK  = 3'd3,
        OP_RD_NACK = 3'd4
    } op_e;

    localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
    localparam logic [7:0] REG_BW_RATE     = 8'h2C;
    localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
    localparam logic [7:0] REG_DATAX0      = 8'h32;

    // Steps 0..19 hold the init list, 20..31 the burst-read list.
    localparam logic [4:0] INIT_FIRST_STEP = 5'd0;
    localparam logic [4:0] READ_FIRST_STEP = 5'd20;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE, S_ABORT, S_ABORT_WAIT, S_ERR
    } state_e;

endpackage

// File: rtl/accel_op_rom.sv
// Combinational step -> I2C command table for both the init and burst-read lists.
// Pure lookup: no state, no handshake.
module accel_op_rom
    import accel_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR        = 7'h53,
    parameter logic [7:0] DATA_FORMAT_VAL = 8'h0B,
    parameter logic [7:0] BW_RATE_VAL     = 8'h0B
) (
    input  logic [4:0] step,
    output logic [2:0] op,
    output logic [7:0] data,
    output logic       last_of_txn,
    output logic       last_of_list
);
    logic [1:0] txn;
    logic [2:0] pos;
    logic [7:0] init_reg;
    logic [7:0] init_val;

    always_comb begin
        op           = OP_START;
        data         = 8'h00;
        last_of_txn  = 1'b0;
        last_of_list = 1'b0;
        txn          = 2'd0;
        pos          = 3'd0;
        init_reg     = REG_POWER_CTL;
        init_val     = 8'h08;
        if (step < READ_FIRST_STEP) begin
            // Each init transaction is START, W addr, W reg, W val, STOP.
            txn = 2'(step / 5'd5);
            pos = 3'(step % 5'd5);
            case (txn)
                2'd0:    begin init_reg = REG_DATA_FORMAT; init_val = DATA_FORMAT_VAL; end
                2'd1:    begin init_reg = REG_BW_RATE;     init_val = BW_RATE_VAL;     end
                2'd2:    begin init_reg = REG_POWER_CTL;   init_val = 8'h00;           end
                default: begin init_reg = REG_POWER_CTL;   init_val = 8'h08;           end
            endcase
            case (pos)
                3'd0:    op = OP_START;
                3'd1:    begin op = OP_WRITE; data = {DEV_ADDR, 1'b0}; end
                3'd2:    begin op = OP_WRITE; data = init_reg; end
                3'd3:    begin op = OP_WRITE; data = init_val; end
                default: begin
                    op           = OP_STOP;
                    last_of_txn  = 1'b1;
                    last_of_list = (txn == 2'd3);
                end
            endcase
        end else begin
            case (step)
                5'd20:   op = OP_START;
                5'd21:   begin op = OP_WRITE; data = {DEV_ADDR, 1'b0}; end
                5'd22:   begin op = OP_WRITE; data = REG_DATAX0; end
                5'd23:   op = OP_START;
                5'd24:   begin op = OP_WRITE; data = {DEV_ADDR, 1'b1}; end
                5'd25, 5'd26, 5'd27, 5'd28, 5'd29: op = OP_RD_ACK;
                5'd30:   op = OP_RD_NACK;
                default: begin
                    op           = OP_STOP;
                    last_of_txn  = 1'b1;
                    last_of_list = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/accel_i2c_sequencer.sv
// ADXL345 sequencer: init writes after reset, then periodic 6-byte burst reads into X/Y/Z.
// One command outstanding; cmd held until cmd_ready. Optional NACK retry under ACCEL_RETRY_EN.
module accel_i2c_sequencer
    import accel_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR        = 7'h53,
    parameter int         SAMPLE_DIV      = 500000,
    parameter logic [7:0] DATA_FORMAT_VAL = 8'h0B,
    parameter logic [7:0] BW_RATE_VAL     = 8'h0B
`ifdef ACCEL_RETRY_EN
    ,
    parameter int         MAX_RETRY       = 3
`endif
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        enable,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_op,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_nack,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        sample_valid,
    output logic        init_done,
    output logic        busy,
    output logic        overrun,
    output logic        error
);
    localparam int CW = $clog2(SAMPLE_DIV + 1);

    state_e        state;
    logic [4:0]    step;
    logic [4:0]    txn_start;
    logic [4:0]    rom_addr;
    logic [2:0]    rom_op;
    logic [7:0]    rom_data;
    logic          rom_last_txn;
    logic          rom_last_list;
    logic          cur_last_txn;
    logic          cur_last_list;
    logic [2:0]    rd_idx;
    logic [7:0]    shadow [6];
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic          retry_ok;
    logic          load_cmd;

`ifdef ACCEL_RETRY_EN
    logic [7:0]    retry_cnt;
    assign retry_ok = (retry_cnt < 8'(MAX_RETRY));
`else
    assign retry_ok = 1'b0;
`endif

    assign tick = init_done && enable && (tick_cnt == CW'(SAMPLE_DIV - 1));
    assign busy = (state != S_IDLE) && (state != S_ERR);

    // The ROM is addressed by the step about to be issued so the command registers load directly.
    always_comb begin
        rom_addr = txn_start;
        if (state == S_IDLE)
            rom_addr = init_done ? READ_FIRST_STEP : INIT_FIRST_STEP;
        else if (state == S_NEXT)
            rom_addr = step + 5'd1;
    end

    assign load_cmd = ((state == S_IDLE) && (!init_done || tick))
                   || ((state == S_NEXT) && !cur_last_list)
                   || ((state == S_ABORT_WAIT) && rsp_valid && retry_ok);

    accel_op_rom #(
        .DEV_ADDR        (DEV_ADDR),
        .DATA_FORMAT_VAL (DATA_FORMAT_VAL),
        .BW_RATE_VAL     (BW_RATE_VAL)
    ) u_rom (
        .step         (rom_addr),
        .op           (rom_op),
        .data         (rom_data),
        .last_of_txn  (rom_last_txn),
        .last_of_list (rom_last_list)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state         <= S_IDLE;
            step          <= '0;
            txn_start     <= '0;
            cur_last_txn  <= 1'b0;
            cur_last_list <= 1'b0;
            rd_idx        <= '0;
            tick_cnt      <= '0;
            cmd_valid     <= 1'b0;
            cmd_op        <= '0;
            cmd_data      <= '0;
            accel_x       <= '0;
            accel_y       <= '0;
            accel_z       <= '0;
            sample_valid  <= 1'b0;
            init_done     <= 1'b0;
            overrun       <= 1'b0;
            error         <= 1'b0;
            for (int i = 0; i < 6; i++) shadow[i] <= '0;
`ifdef ACCEL_RETRY_EN
            retry_cnt     <= '0;
`endif
        end else begin
            sample_valid <= 1'b0;
            overrun      <= tick && (state != S_IDLE);
            if (init_done && enable)
                tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
            else
                tick_cnt <= '0;

            case (state)
                S_ISSUE: if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    state     <= S_WAIT;
                end
                S_WAIT: if (rsp_valid) begin
                    if (cmd_op == OP_WRITE && rsp_nack) begin
                        cmd_valid <= 1'b1;
                        cmd_op    <= OP_STOP;
                        cmd_data  <= 8'h00;
                        state     <= S_ABORT;
                    end else begin
                        if (cmd_op == OP_RD_ACK || cmd_op == OP_RD_NACK) begin
                            shadow[rd_idx] <= rsp_data;
                            rd_idx         <= rd_idx + 3'd1;
                        end
                        state <= S_NEXT;
                    end
                end
                S_NEXT: if (cur_last_list) state <= S_DONE;
                S_DONE: begin
                    if (init_done) begin
                        accel_x      <= {shadow[1], shadow[0]};
                        accel_y      <= {shadow[3], shadow[2]};
                        accel_z      <= {shadow[5], shadow[4]};
                        sample_valid <= 1'b1;
                    end else begin
                        init_done <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                S_ABORT: if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    state     <= S_ABORT_WAIT;
                end
                S_ABORT_WAIT: if (rsp_valid) begin
                    if (!retry_ok) begin
                        error <= 1'b1;
                        state <= S_ERR;
                    end
`ifdef ACCEL_RETRY_EN
                    else retry_cnt <= retry_cnt + 8'd1;
`endif
                end
                default: ;
            endcase

            if (load_cmd) begin
                state         <= S_ISSUE;
                step          <= rom_addr;
                cmd_valid     <= 1'b1;
                cmd_op        <= rom_op;
                cmd_data      <= rom_data;
                cur_last_txn  <= rom_last_txn;
                cur_last_list <= rom_last_list;
                if (state != S_NEXT) rd_idx <= '0;
                // A new transaction gets a fresh restart point and retry budget.
                if (state == S_IDLE || (state == S_NEXT && cur_last_txn)) begin
                    txn_start <= rom_addr;
`ifdef ACCEL_RETRY_EN
                    retry_cnt <= '0;
`endif
                end
            end
        end
    end

endmodule
